// File: rtl/gbuff_stream_reader_pkg.sv
// rtl/gbuff_stream_reader_pkg.sv - shared widths and reader state codes
package gbuff_stream_reader_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int GBUFF_INDX_SIZE = 8;
  localparam int RDR_LEN_W       = 9;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_RUN   = 2'd1,
    RDR_DRAIN = 2'd2
  } rdr_state_e;

endpackage

// File: rtl/gbuff_stream_reader_skid_fifo.sv
// rtl/gbuff_stream_reader_skid_fifo.sv - 2-entry skid FIFO holding {last, data}
module gbuff_skid_fifo
  import gbuff_stream_reader_pkg::*;
#(
  parameter int W = WORD_SIZE + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/gbuff_stream_reader.sv
// rtl/gbuff_stream_reader.sv - strided global-buffer read master streaming words out
module gbuff_stream_reader
  import gbuff_stream_reader_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int INDX_W = GBUFF_INDX_SIZE,
  parameter int LEN_W  = RDR_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [INDX_W-1:0] base_addr_i,
  input  logic [INDX_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  length_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              gb_wr_en_o,
  output logic [INDX_W-1:0] gb_index_o,
  output logic [WORD_W-1:0] gb_data_in_o,
  input  logic [WORD_W-1:0] gb_data_out_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_last_o
);

  rdr_state_e        state_q;
  logic [INDX_W-1:0] idx_q;
  logic [INDX_W-1:0] stride_q;
  logic [LEN_W-1:0]  rem_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              done_q;

  logic [WORD_W:0]   head;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              issue;

  assign pop = out_valid_o && out_ready_i;

  // Credit check: FIFO entries plus the word on its way must leave room after this cycle's pop.
  assign issue = (state_q == RDR_RUN) &&
                 (({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  gbuff_skid_fifo #(.W(WORD_W + 1)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, gb_data_out_i}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  assign out_valid_o  = (fifo_cnt != 2'd0);
  assign out_data_o   = head[WORD_W-1:0];
  assign out_last_o   = out_valid_o && head[WORD_W];
  assign gb_index_o   = idx_q;
  assign gb_wr_en_o   = 1'b0;
  assign gb_data_in_o = '0;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= RDR_IDLE;
      idx_q           <= '0;
      stride_q        <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_W'(1));
      case (state_q)
        RDR_IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              state_q  <= RDR_RUN;
              busy_q   <= 1'b1;
              idx_q    <= base_addr_i;
              stride_q <= stride_i;
              rem_q    <= length_i;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RDR_RUN: begin
          if (issue) begin
            idx_q <= idx_q + stride_q;
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= RDR_DRAIN;
            end
          end
        end
        RDR_DRAIN: begin
          if (pop && out_last_o) begin
            state_q <= RDR_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RDR_IDLE;
      endcase
    end
  end

endmodule
